instr_mem_loader: RTL

//   Parametrised synchronous instruction memory with separate load and fetch ports.

---
 rtl/instr_mem_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming valid/ready load port and a 1-cycle registered fetch port.
// Optional build macro INSTR_MEM_PARITY_EN adds a stored even-parity bit per word and parity_err checking.
module instr_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_wrap,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  fetch_go;

    assign load_ready = (state == LOAD);
    assign load_busy  = (state == LOAD);
    assign accept     = load_valid && load_ready;
    // A load_start in IDLE pre-empts a simultaneous fetch request.
    assign fetch_go   = fetch_req && !fetch_stall && (state == IDLE) && !load_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD:    if (accept && load_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- load session bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            load_count <= '0;
            load_wrap  <= 1'b0;
        end else if (state == IDLE && load_start) begin
            wptr       <= load_base;
            load_count <= '0;
            load_wrap  <= 1'b0;
        end else if (accept) begin
            wptr <= wptr + 1'b1;
            if (wptr == '1)              load_wrap  <= 1'b1;
            if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
        end
    end

    // Storage is never reset so a reset mid-load keeps already written words.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= load_data;
    end

    // ---- fetch stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
        end else if (!fetch_stall) begin
            fetch_valid <= fetch_go;
            if (fetch_go) fetch_data <= mem[fetch_addr];
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (accept) par_mem[wptr] <= word_parity(load_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (!fetch_stall) begin
            if (fetch_go) parity_err <= word_parity(mem[fetch_addr]) ^ par_mem[fetch_addr];
            else          parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
